// File: rtl/shared_mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port byte-enabled memory; grant is combinational, read data appears 2 cycles after grant.
// Reads are credit-limited by a 2-entry response FIFO (stall while full); writes are posted and never stall on responses.
module shared_mem_rr_arbiter #(
   parameter int NUM_REQS = 4,
   parameter int DATAW    = 32,
   parameter int SIZE     = 1024,
   parameter int BYTEENW  = DATAW / 8,
   parameter int ADDRW    = $clog2(SIZE),
   parameter int IDW      = $clog2(NUM_REQS)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NUM_REQS-1:0]           req_valid_i,
   input  logic [NUM_REQS-1:0]           req_rw_i,
   input  logic [NUM_REQS*ADDRW-1:0]     req_addr_i,
   input  logic [NUM_REQS*BYTEENW-1:0]   req_byteen_i,
   input  logic [NUM_REQS*DATAW-1:0]     req_wdata_i,
   output logic [NUM_REQS-1:0]           req_ready_o,
   output logic                          rsp_valid_o,
   output logic [IDW-1:0]                rsp_id_o,
   output logic [DATAW-1:0]              rsp_data_o,
   input  logic                          rsp_ready_i,
   output logic [ADDRW-1:0]              mem_addr_o,
   output logic [BYTEENW-1:0]            mem_wren_o,
   output logic [DATAW-1:0]              mem_wdata_o,
   input  logic [DATAW-1:0]              mem_rdata_i
);

   logic [IDW-1:0]   rr_q, rr_d;
   logic             inflight_q, inflight_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [DATAW-1:0] fifo_data_q [2];
   logic [IDW-1:0]   fifo_id_q [2];
   logic             rd_ptr_q, wr_ptr_q;
   logic [1:0]       count_q;

   logic                rsp_fire, read_ok, gnt_vld, gnt_rd, push;
   logic [IDW-1:0]      gnt_idx;
   logic [NUM_REQS-1:0] elig;
   logic [2:0]          occ;

   assign rsp_valid_o = (count_q != 2'd0);
   assign rsp_id_o    = fifo_id_q[rd_ptr_q];
   assign rsp_data_o  = fifo_data_q[rd_ptr_q];
   assign rsp_fire    = rsp_valid_o & rsp_ready_i;

   // A pop in this cycle frees a slot immediately, so reads can stream at one per cycle.
   assign occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, rsp_fire};
   assign read_ok = (occ < 3'd2);
   assign elig    = req_valid_i & (req_rw_i | {NUM_REQS{read_ok}}) & {NUM_REQS{rst_ni}};

   always_comb begin : arb
      int j;
      logic [IDW-1:0] cand;
      j       = 0;
      cand    = '0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         j = int'(rr_q) + i;
         if (j >= NUM_REQS) j = j - NUM_REQS;
         cand = IDW'(j);
         if (!gnt_vld && elig[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_comb begin
      req_ready_o = '0;
      mem_addr_o  = '0;
      mem_wren_o  = '0;
      mem_wdata_o = '0;
      gnt_rd      = 1'b0;
      if (gnt_vld) begin
         req_ready_o[gnt_idx] = 1'b1;
         mem_addr_o = req_addr_i[int'(gnt_idx)*ADDRW +: ADDRW];
         if (req_rw_i[gnt_idx]) begin
            mem_wren_o  = req_byteen_i[int'(gnt_idx)*BYTEENW +: BYTEENW];
            mem_wdata_o = req_wdata_i[int'(gnt_idx)*DATAW +: DATAW];
         end else begin
            gnt_rd = 1'b1;
         end
      end
   end

   always_comb begin
      rr_d       = rr_q;
      inflight_d = gnt_rd;
      id_d       = id_q;
      if (gnt_vld) rr_d = (gnt_idx == IDW'(NUM_REQS - 1)) ? '0 : gnt_idx + IDW'(1);
      if (gnt_rd)  id_d = gnt_idx;
   end

   assign push = inflight_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q           <= '0;
         inflight_q     <= 1'b0;
         id_q           <= '0;
         rd_ptr_q       <= 1'b0;
         wr_ptr_q       <= 1'b0;
         count_q        <= 2'd0;
         fifo_data_q[0] <= '0;
         fifo_data_q[1] <= '0;
         fifo_id_q[0]   <= '0;
         fifo_id_q[1]   <= '0;
      end else begin
         rr_q       <= rr_d;
         inflight_q <= inflight_d;
         id_q       <= id_d;
         if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_rdata_i;
            fifo_id_q[wr_ptr_q]   <= id_q;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (rsp_fire) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push} - {1'b0, rsp_fire};
      end
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push && (count_q == 2'd2) && !rsp_fire));

endmodule

// File: tb/tb_shared_mem_rr_arbiter.sv
// Randomized and directed bench for shared_mem_rr_arbiter with a queue-based reference model and response scoreboard.
module tb_shared_mem_rr_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int SZ = 1024;
   localparam int BW = 4;
   localparam int AW = 10;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst_ni = 1'b0;
   logic [N-1:0]    req_valid = '0, req_rw = '0, req_ready;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*BW-1:0] req_byteen = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic            rsp_valid, rsp_ready = 1'b0;
   logic [IW-1:0]   rsp_id;
   logic [DW-1:0]   rsp_data;
   logic [AW-1:0]   mem_addr;
   logic [BW-1:0]   mem_wren;
   logic [DW-1:0]   mem_wdata, mem_rdata;

   shared_mem_rr_arbiter #(.NUM_REQS(N), .DATAW(DW), .SIZE(SZ)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid), .req_rw_i(req_rw), .req_addr_i(req_addr),
      .req_byteen_i(req_byteen), .req_wdata_i(req_wdata), .req_ready_o(req_ready),
      .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .rsp_ready_i(rsp_ready),
      .mem_addr_o(mem_addr), .mem_wren_o(mem_wren), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;

   // Single-port memory with registered read (read-old-data on the same edge as a write).
   logic [DW-1:0] ram [SZ];
   always @(posedge clk) begin
      mem_rdata <= ram[mem_addr];
      for (int b = 0; b < BW; b++)
         if (mem_wren[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int            id;
      logic [DW-1:0] data;
      int            rdy;
   } exp_t;
   exp_t exp_q[$];

   // Reference model: outstanding reads are simply the entries not yet consumed from exp_q.
   logic [DW-1:0] ref_mem [SZ];
   int ptr;
   initial begin
      logic [N-1:0]  exp_rdy;
      logic [DW-1:0] exp_wdata;
      logic [BW-1:0] exp_wren;
      int exp_k, k, a;
      bit fire, read_ok;
      ptr = 0;
      for (int i = 0; i < SZ; i++) ref_mem[i] = '0;
      forever begin
         @(negedge clk);
         if (!rst_ni) begin
            exp_q.delete();
            ptr = 0;
            continue;
         end
         fire    = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc) && rsp_ready;
         read_ok = (exp_q.size() - int'(fire)) < 2;
         exp_k   = -1;
         for (int i = 0; i < N; i++) begin
            k = (ptr + i) % N;
            if (exp_k < 0 && req_valid[k] && (req_rw[k] || read_ok)) exp_k = k;
         end
         exp_rdy = '0; exp_wren = '0; exp_wdata = '0; a = 0;
         if (exp_k >= 0) begin
            exp_rdy[exp_k] = 1'b1;
            a = int'(req_addr[exp_k*AW +: AW]);
            if (req_rw[exp_k]) begin
               exp_wren  = req_byteen[exp_k*BW +: BW];
               exp_wdata = req_wdata[exp_k*DW +: DW];
            end
         end
         chk("grant", 64'(req_ready), 64'(exp_rdy));
         chk("mem_addr", 64'(mem_addr), 64'(a));
         chk("mem_wren", 64'(mem_wren), 64'(exp_wren));
         chk("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
         if (exp_k >= 0) begin
            ptr = (exp_k + 1) % N;
            if (req_rw[exp_k]) begin
               for (int b = 0; b < BW; b++)
                  if (exp_wren[b]) ref_mem[a][b*8 +: 8] = exp_wdata[b*8 +: 8];
            end else begin
               exp_q.push_back('{id: exp_k, data: ref_mem[a], rdy: cyc + 2});
            end
         end
      end
   end

   // Monitor: runs just after the model in the same half-cycle and retires fired responses.
   initial begin
      bit hold, exp_v;
      logic [IW-1:0] h_id;
      logic [DW-1:0] h_data;
      hold = 0; h_id = '0; h_data = '0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_ni) begin
            hold = 0;
            continue;
         end
         exp_v = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
         chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
         if (hold) begin
            chk("hold_id", 64'(rsp_id), 64'(h_id));
            chk("hold_data", 64'(rsp_data), 64'(h_data));
         end
         if (exp_v) begin
            chk("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
            chk("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
            if (rsp_ready) void'(exp_q.pop_front());
         end
         hold = rsp_valid && !rsp_ready;
         h_id = rsp_id; h_data = rsp_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input bit v, input bit rw, input int addr,
                          input logic [BW-1:0] be, input logic [DW-1:0] d);
      req_valid[k]            = v;
      req_rw[k]               = rw;
      req_addr[k*AW +: AW]    = AW'(addr);
      req_byteen[k*BW +: BW]  = be;
      req_wdata[k*DW +: DW]   = d;
   endtask

   task automatic idle();
      for (int k = 0; k < N; k++) set_req(k, 0, 0, 0, '0, '0);
   endtask

   task automatic reset_checks();
      @(negedge clk);
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_id", 64'(rsp_id), 64'(0));
      chk("rst_rsp_data", 64'(rsp_data), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      chk("rst_mem_wren", 64'(mem_wren), 64'(0));
      chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
   endtask

   initial begin
      idle();
      reset_checks();
      tick();
      rst_ni = 1'b1;
      rsp_ready = 1'b1;

      // Initialise words 0..31 via requester 0; word 5 gets 0xDEADBEEF.
      for (int i = 0; i < 32; i++) begin
         set_req(0, 1, 1, i, 4'hF, (i == 5) ? 32'hDEADBEEF : 32'h0);
         tick();
      end
      idle();

      // All four requesters write continuously.
      for (int k = 0; k < N; k++) set_req(k, 1, 1, 'h10 + k, 4'hF, 32'hA0 + k);
      repeat (8) tick();
      idle();

      // Single read from requester 2.
      set_req(2, 1, 0, 5, '0, '0);
      tick();
      idle();
      repeat (4) tick();

      // Back-to-back reads from requesters 0 and 1.
      set_req(0, 1, 0, 'h10, '0, '0);
      set_req(1, 1, 0, 'h11, '0, '0);
      repeat (10) tick();
      idle();
      repeat (3) tick();

      // Back-pressure: three readers plus a writer, consumer stalled.
      rsp_ready = 1'b0;
      set_req(0, 1, 0, 'h12, '0, '0);
      set_req(1, 1, 0, 'h13, '0, '0);
      set_req(2, 1, 0, 5, '0, '0);
      set_req(3, 1, 1, 'h14, 4'hF, 32'h5555AAAA);
      repeat (6) tick();
      rsp_ready = 1'b1;
      repeat (6) tick();
      idle();
      repeat (3) tick();

      // Partial byte-enable write followed immediately by a read of the same word.
      set_req(1, 1, 1, 7, 4'b0101, 32'h11223344);
      tick();
      set_req(1, 1, 0, 7, '0, '0);
      tick();
      idle();
      repeat (4) tick();

      // Reset while the response FIFO is full.
      rsp_ready = 1'b0;
      set_req(0, 1, 0, 3, '0, '0);
      set_req(1, 1, 0, 4, '0, '0);
      repeat (5) tick();
      rst_ni = 1'b0;
      reset_checks();
      tick();
      for (int k = 0; k < N; k++) set_req(k, 1, 1, 'h10 + k, 4'hF, 32'hA0 + k);
      rsp_ready = 1'b1;
      rst_ni = 1'b1;
      @(negedge clk);
      chk("post_rst_grant0", 64'(req_ready), 64'(1));
      chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
      tick();
      idle();
      repeat (3) tick();

      // Random traffic over a small address window so same-address hazards occur.
      for (int c = 0; c < 1500; c++) begin
         for (int k = 0; k < N; k++)
            set_req(k, 1'($urandom), 1'($urandom), int'($urandom_range(0, 31)),
                    BW'($urandom), $urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      idle();
      rsp_ready = 1'b1;
      repeat (6) tick();
      @(negedge clk);
      #2;
      chk("drained", 64'(exp_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
